simple_spi_slave: RTL and testbench
===================================

SIMPLE_SPI_SLAVE -- requirements
Module: simple_spi_slave

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state resets when rst_ni is low.
REQ-002 Parameter: SYNC_STAGES, default 2, flops per input synchronizer for sck_i, ss_ni, mosi_i (legal 2..3).
REQ-003 Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  async active-low reset
- cyc_i  input  1  WISHBONE cycle
- stb_i  input  1  WISHBONE strobe
- adr_i  input  3  register address
- we_i  input  1  write enable
- dat_i  input  8  write data
- dat_o  output  8  read data (registered)
- ack_o  output  1  bus termination
- inta_o  output  1  interrupt (registered)
- sck_i  input  1  SPI clock from master (async)
- ss_ni  input  1  slave select, active low (async)
- mosi_i  input  1  master out slave in (async)
- miso_o  output  1  slave out
- miso_oe_o  output  1  miso drive enable (high only while selected and spe=1)

Function
REQ-004 ack_o SHALL be ack_o <= cyc_i & stb_i & ~ack_o (one wait state, one-cycle pulse); dat_o SHALL update every cycle from adr_i.
REQ-005 Map: 000 SPCR rw {spie[7], spe[6], cpol[3], cpha[2], others read 0}; 001 SPSR; 010 SPDR (write pushes TX FIFO, read pops RX FIFO); 011 BCNT ro, 8-bit count of completed bytes in current selection; other addresses read 0, writes ignored.
REQ-006 SPSR: [7] spif, [6] wcol, [5] rovr, [4] tudr (bits 7..4 write-1-to-clear); [3] txfull, [2] txempty, [1] rxfull, [0] rxempty.
REQ-007 SPDR push/pop SHALL occur only on the ack_o cycle of the access (one per access).
REQ-008 TX and RX FIFOs SHALL each be 4 entries x 8 bits, flushed while spe=0.
REQ-009 sck_i, ss_ni, mosi_i SHALL pass through SYNC_STAGES flops; sck edges detected on the synchronized signal; clk_i >= 8x SCK frequency required.
REQ-010 Leading edge = sck leaving cpol level; trailing edge = returning to cpol.
REQ-011 States: IDLE (ss deasserted or spe=0), ACTIVE (selected); IDLE->ACTIVE on synchronized ss falling with spe=1; ACTIVE->IDLE on ss rising or spe cleared.
REQ-012 On each byte start (ss falling, or completion of previous byte while still selected): shift register loads TX head and pops it; if TX empty, loads 8'hFF and sets tudr.
REQ-013 cpha=0: miso_o presents bit7 at byte start; mosi sampled on leading edge; shift out on trailing edge.
REQ-014 cpha=1: shift out on leading edge (first leading edge presents bit7); sample on trailing edge.
REQ-015 MSB first; 3-bit bit counter; after 8th sample the received byte SHALL be pushed to RX one clk_i later, spif set, BCNT incremented (wraps 255->0).
REQ-016 RX full at push: byte dropped, rovr set, RX contents unchanged.
REQ-017 SPDR write with TX full: data dropped, wcol set.
REQ-018 ss rising mid-byte: partial byte discarded, bit counter cleared, no RX push, no spif; BCNT clears on next ss falling.
REQ-019 Flag set and W1C in the same cycle: set wins.
REQ-020 spe=0: FIFOs flushed, flags cleared, state IDLE, miso_oe_o=0, miso_o=1.
REQ-021 inta_o <= spie & (spif | rovr).
REQ-022 SPCR writes while ACTIVE take effect at next byte start only (cpol/cpha latched at byte start).

Reset
REQ-023 Reset values: SPCR=8'h00, all flags 0, FIFOs empty, BCNT=0, state IDLE, dat_o=0, ack_o=0, inta_o=0, miso_o=1, miso_oe_o=0, synchronizers=idle levels (ss high, sck low, mosi 0).

Verification
REQ-024 Mode 0: SPCR=8'h40, push 8'hA5, master sends 8'h3C with ss low -> MISO carries A5 MSB first, RX=3C, spif=1, BCNT=1.
REQ-025 Mode 3 (SPCR=8'h4C), push 11,22, 2-byte transfer of C3,5A -> MISO 11,22; RX 2 entries C3 then 5A; SPSR[7]=1.
REQ-026 TX empty at ss falling -> MISO 8'hFF, tudr=1; write SPSR 8'h10 -> tudr=0.
REQ-027 Five bytes received without reads -> RX holds first 4, rovr=1, inta_o=1 with spie=1.
REQ-028 ss raised after 4 SCK cycles -> no RX push, spif=0; next full byte received correctly.
REQ-029 Reset asserted mid-byte -> all outputs at REQ-023 values immediately, FIFOs empty after release.

Source files
------------

// File: rtl/simple_spi_slave.sv
// SPI slave with a WISHBONE register port, 4-deep TX/RX FIFOs and status flags.
// SPI pins are synchronized into clk_i; all shifting is driven by edges of the synchronized sck.
module simple_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic [2:0] adr_i,
  input  logic       we_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       inta_o,
  input  logic       sck_i,
  input  logic       ss_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o
);
  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [2:0] A_SPCR = 3'd0;
  localparam logic [2:0] A_SPSR = 3'd1;
  localparam logic [2:0] A_SPDR = 3'd2;
  localparam logic [2:0] A_BCNT = 3'd3;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic sck_prev_q, ss_prev_q;
  logic sck_s, ss_s, mosi_s;

  state_e state_q, state_d;
  logic [3:0] spcr_q, spcr_d;  // {spie, spe, cpol, cpha}
  logic [3:0] flg_q, flg_d;    // {spif, wcol, rovr, tudr}
  logic [3:0][7:0] tx_mem_q, tx_mem_d, rx_mem_q, rx_mem_d;
  logic [1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [2:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, bit_q, bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d, bcnt_q, bcnt_d;
  logic [7:0] dat_q, dat_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, full_q, full_d, push_q, push_d;
  logic miso_q, miso_d, ack_q, ack_d, inta_q, inta_d;

  logic spe, wr, rd, sck_edge, lead, trail, samp, shft, ss_fall, last, start;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [3:0] set, clr;
  logic [7:0] ld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_ni};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign spe      = spcr_q[2];
  assign wr       = ack_q & cyc_i & stb_i & we_i;
  assign rd       = ack_q & cyc_i & stb_i & ~we_i;
  assign sck_edge = sck_s ^ sck_prev_q;
  assign lead     = sck_edge & (sck_s != cpol_q);
  assign trail    = sck_edge & (sck_s == cpol_q);
  assign samp     = cpha_q ? trail : lead;
  assign shft     = cpha_q ? lead : trail;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign last     = samp & (bit_q == 3'd7);

  always_comb begin
    state_d = state_q;  spcr_d = spcr_q;  flg_d = flg_q;
    tx_mem_d = tx_mem_q;  tx_wp_d = tx_wp_q;  tx_rp_d = tx_rp_q;  tx_cnt_d = tx_cnt_q;
    rx_mem_d = rx_mem_q;  rx_wp_d = rx_wp_q;  rx_rp_d = rx_rp_q;  rx_cnt_d = rx_cnt_q;
    bit_d = bit_q;  tx_sh_d = tx_sh_q;  rx_sh_d = rx_sh_q;  rx_byte_d = rx_byte_q;
    bcnt_d = bcnt_q;  cpol_d = cpol_q;  cpha_d = cpha_q;  full_d = full_q;
    miso_d = miso_q;  push_d = 1'b0;
    set = '0;  clr = '0;  start = 1'b0;  ld = 8'hFF;
    tx_push = wr & (adr_i == A_SPDR) & (tx_cnt_q != 3'd4);
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    rx_pop  = rd & (adr_i == A_SPDR) & (rx_cnt_q != 3'd0);

    if (wr && adr_i == A_SPCR) spcr_d = {dat_i[7:6], dat_i[3:2]};
    if (wr && adr_i == A_SPSR) clr = dat_i[7:4];
    if (wr && adr_i == A_SPDR && tx_cnt_q == 3'd4) set[2] = 1'b1;

    // Received byte lands one cycle after its last sample.
    if (push_q && spe) begin
      set[3] = 1'b1;
      bcnt_d = bcnt_q + 8'd1;
      if (rx_cnt_q == 3'd4) set[1] = 1'b1;
      else                  rx_push = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (spe && ss_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
          bcnt_d  = '0;
        end
      end
      default: begin
        if (!spe || ss_s) begin
          state_d = IDLE;
          bit_d   = '0;
          full_d  = 1'b0;
          miso_d  = 1'b1;
        end else begin
          if (samp) begin
            rx_sh_d = {rx_sh_q[6:0], mosi_s};
            bit_d   = bit_q + 3'd1;
          end
          if (last) begin
            push_d    = 1'b1;
            rx_byte_d = {rx_sh_q[6:0], mosi_s};
            full_d    = 1'b1;
          end
          // Next byte is loaded on the trailing edge that closes the current one.
          if (trail && (full_q || last)) start = 1'b1;
          else if (shft) begin
            miso_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
    endcase

    if (start) begin
      cpol_d = spcr_q[1];
      cpha_d = spcr_q[0];
      bit_d  = '0;
      full_d = 1'b0;
      if (tx_cnt_q != 3'd0) begin
        ld     = tx_mem_q[tx_rp_q];
        tx_pop = 1'b1;
      end else set[0] = 1'b1;
      // cpha=0 already presents bit7, so the register holds the remaining bits.
      tx_sh_d = spcr_q[0] ? ld : {ld[6:0], 1'b0};
      miso_d  = ld[7];
    end

    if (tx_push) begin
      tx_mem_d[tx_wp_q] = dat_i;
      tx_wp_d = tx_wp_q + 2'd1;
    end
    if (tx_pop) tx_rp_d = tx_rp_q + 2'd1;
    tx_cnt_d = tx_cnt_q + {2'b0, tx_push} - {2'b0, tx_pop};
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = rx_byte_q;
      rx_wp_d = rx_wp_q + 2'd1;
    end
    if (rx_pop) rx_rp_d = rx_rp_q + 2'd1;
    rx_cnt_d = rx_cnt_q + {2'b0, rx_push} - {2'b0, rx_pop};
    flg_d = (flg_q & ~clr) | set;

    if (!spe) begin
      tx_wp_d = '0;  tx_rp_d = '0;  tx_cnt_d = '0;
      rx_wp_d = '0;  rx_rp_d = '0;  rx_cnt_d = '0;
      flg_d = '0;
    end

    ack_d  = cyc_i & stb_i & ~ack_q;
    inta_d = spcr_q[3] & (flg_q[3] | flg_q[1]);
    case (adr_i)
      A_SPCR:  dat_d = {spcr_q[3:2], 2'b00, spcr_q[1:0], 2'b00};
      A_SPSR:  dat_d = {flg_q, tx_cnt_q == 3'd4, tx_cnt_q == 3'd0, rx_cnt_q == 3'd4, rx_cnt_q == 3'd0};
      A_SPDR:  dat_d = (rx_cnt_q != 3'd0) ? rx_mem_q[rx_rp_q] : 8'h00;
      A_BCNT:  dat_d = bcnt_q;
      default: dat_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;  spcr_q <= '0;  flg_q <= '0;
      tx_mem_q <= '0;  tx_wp_q <= '0;  tx_rp_q <= '0;  tx_cnt_q <= '0;
      rx_mem_q <= '0;  rx_wp_q <= '0;  rx_rp_q <= '0;  rx_cnt_q <= '0;
      bit_q <= '0;  tx_sh_q <= '0;  rx_sh_q <= '0;  rx_byte_q <= '0;  bcnt_q <= '0;
      cpol_q <= 1'b0;  cpha_q <= 1'b0;  full_q <= 1'b0;  push_q <= 1'b0;
      miso_q <= 1'b1;  ack_q <= 1'b0;  inta_q <= 1'b0;  dat_q <= '0;
    end else begin
      state_q <= state_d;  spcr_q <= spcr_d;  flg_q <= flg_d;
      tx_mem_q <= tx_mem_d;  tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_cnt_q <= tx_cnt_d;
      rx_mem_q <= rx_mem_d;  rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;  rx_cnt_q <= rx_cnt_d;
      bit_q <= bit_d;  tx_sh_q <= tx_sh_d;  rx_sh_q <= rx_sh_d;  rx_byte_q <= rx_byte_d;  bcnt_q <= bcnt_d;
      cpol_q <= cpol_d;  cpha_q <= cpha_d;  full_q <= full_d;  push_q <= push_d;
      miso_q <= miso_d;  ack_q <= ack_d;  inta_q <= inta_d;  dat_q <= dat_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign inta_o    = inta_q;
  assign miso_o    = miso_q | ~spe;
  assign miso_oe_o = (state_q == ACTIVE) & spe;
endmodule

// File: tb/tb_simple_spi_slave.sv
// Bench for simple_spi_slave: bit-banged SPI master plus a queue-based model of FIFOs, flags and BCNT.
module tb_simple_spi_slave;
  localparam int H = 8;  // clk cycles per SCK half period

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0] adr = '0;
  logic [7:0] wdat = '0, rdat;
  logic       ack, inta, miso, miso_oe;
  logic       sck = 1'b0, ss = 1'b1, mosi = 1'b0;

  always #5 clk = ~clk;

  simple_spi_slave dut (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .we_i(we),
    .dat_i(wdat), .dat_o(rdat), .ack_o(ack), .inta_o(inta),
    .sck_i(sck), .ss_ni(ss), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe)
  );

  int total = 0, bad = 0;

  logic [7:0] m_tx[$], m_rx[$];
  logic [3:0] m_flg;  // {spif, wcol, rovr, tudr}
  logic [7:0] m_bcnt;
  logic       m_spie, m_cpol, m_cpha;
  logic [7:0] tx_buf[6], mo_buf[8];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    chk("ack_wr", ack, 1'b1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    d = rdat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  function automatic logic [7:0] m_start();
    if (m_tx.size() > 0) return m_tx.pop_front();
    m_flg[0] = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void m_done(input logic [7:0] b);
    if (m_rx.size() == 4) m_flg[1] = 1'b1;
    else m_rx.push_back(b);
    m_flg[3] = 1'b1;
    m_bcnt = m_bcnt + 8'd1;
  endfunction

  function automatic logic [7:0] m_spsr();
    return {m_flg, m_tx.size() == 4, m_tx.size() == 0, m_rx.size() == 4, m_rx.size() == 0};
  endfunction

  task automatic setup(input logic [7:0] spcr, input int ntx);
    bus_wr(3'd0, 8'h00);
    m_tx.delete(); m_rx.delete(); m_flg = '0;
    bus_wr(3'd0, spcr);
    m_spie = spcr[7]; m_cpol = spcr[3]; m_cpha = spcr[2];
    sck = spcr[3];
    wait_clk(4);
    for (int i = 0; i < ntx; i++) begin
      bus_wr(3'd2, tx_buf[i]);
      if (m_tx.size() == 4) m_flg[2] = 1'b1;
      else m_tx.push_back(tx_buf[i]);
    end
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      if (!m_cpha) begin
        mosi = mo[7-k]; wait_clk(H);
        mi[7-k] = miso; sck = ~m_cpol; wait_clk(H);
        sck = m_cpol;
      end else begin
        sck = ~m_cpol; mosi = mo[7-k]; wait_clk(H);
        mi[7-k] = miso; sck = m_cpol; wait_clk(H);
      end
    end
  endtask

  task automatic xfer(input int nb, input int last_bits);
    logic [7:0] mi, cur;
    int nbits;
    ss = 1'b0; m_bcnt = 8'h00; cur = m_start();
    wait_clk(H);
    chk("miso_oe_on", miso_oe, 1'b1);
    for (int i = 0; i < nb; i++) begin
      nbits = (i == nb - 1) ? last_bits : 8;
      spi_byte(mo_buf[i], nbits, mi);
      if (nbits == 8) begin
        chk($sformatf("miso_byte%0d", i), mi, cur);
        m_done(mo_buf[i]);
        cur = m_start();
      end
    end
    wait_clk(H); ss = 1'b1; wait_clk(H);
    chk("miso_oe_off", miso_oe, 1'b0);
  endtask

  task automatic post(input logic [7:0] w1c);
    logic [7:0] d;
    bus_rd(3'd1, d); chk("spsr", d, m_spsr());
    bus_rd(3'd3, d); chk("bcnt", d, m_bcnt);
    chk("inta", inta, m_spie & (m_flg[3] | m_flg[1]));
    while (m_rx.size() > 0) begin
      bus_rd(3'd2, d);
      chk("rxdata", d, m_rx.pop_front());
    end
    bus_wr(3'd1, w1c);
    m_flg = m_flg & ~w1c[7:4];
    wait_clk(2);
    bus_rd(3'd1, d); chk("spsr_w1c", d, m_spsr());
    chk("inta_w1c", inta, m_spie & (m_flg[3] | m_flg[1]));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, mi;
    m_flg = '0; m_bcnt = '0; m_spie = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
    #2 rst_n = 1'b0;
    wait_clk(3);
    chk("rst_dat", rdat, 8'h00);
    chk("rst_ack", ack, 1'b0);
    chk("rst_inta", inta, 1'b0);
    chk("rst_miso", miso, 1'b1);
    chk("rst_oe", miso_oe, 1'b0);
    rst_n = 1'b1;
    wait_clk(2);
    bus_rd(3'd1, d); chk("rst_spsr", d, 8'h05);
    bus_rd(3'd0, d); chk("rst_spcr", d, 8'h00);
    bus_rd(3'd3, d); chk("rst_bcnt", d, 8'h00);
    bus_wr(3'd5, 8'hFF);
    bus_rd(3'd5, d); chk("unmapped", d, 8'h00);

    // mode 0, single byte
    tx_buf[0] = 8'hA5; mo_buf[0] = 8'h3C;
    setup(8'h40, 1);
    bus_rd(3'd0, d); chk("spcr_rd", d, 8'h40);
    xfer(1, 8); post(8'hF0);

    // mode 3, two bytes
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; mo_buf[0] = 8'hC3; mo_buf[1] = 8'h5A;
    setup(8'h4C, 2); xfer(2, 8); post(8'h80);

    // TX underrun, then clear tudr alone
    mo_buf[0] = 8'h96;
    setup(8'h40, 0); xfer(1, 8); post(8'h10);

    // overrun with interrupts, plus TX write collision
    for (int i = 0; i < 6; i++) tx_buf[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) mo_buf[i] = 8'($urandom);
    setup(8'hC0, 5); xfer(5, 8); post(8'hF0);

    // abort after 4 SCK cycles, then a full byte
    tx_buf[0] = 8'h5E; tx_buf[1] = 8'h7B; mo_buf[0] = 8'hE1;
    setup(8'h44, 2); xfer(1, 4); post(8'h00);
    mo_buf[0] = 8'($urandom);
    xfer(1, 8); post(8'hF0);

    for (int it = 0; it < 8; it++) begin
      logic [7:0] spcr;
      int ntx, nb;
      spcr = {1'($urandom), 1'b1, 2'b00, 2'($urandom), 2'b00};
      ntx = $urandom_range(0, 5);
      nb  = $urandom_range(1, 5);
      for (int i = 0; i < 6; i++) tx_buf[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) mo_buf[i] = 8'($urandom);
      setup(spcr, ntx); xfer(nb, 8); post(8'($urandom) & 8'hF0);
    end

    // reset in the middle of a byte
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h34;
    setup(8'h40, 2);
    @(negedge clk); adr = 3'd1;
    ss = 1'b0; wait_clk(H);
    spi_byte(8'hA9, 3, mi);
    rst_n = 1'b0; #1;
    chk("mid_rst_dat", rdat, 8'h00);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_inta", inta, 1'b0);
    chk("mid_rst_miso", miso, 1'b1);
    chk("mid_rst_oe", miso_oe, 1'b0);
    wait_clk(2);
    ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    bus_rd(3'd1, d); chk("post_rst_spsr", d, 8'h05);
    bus_rd(3'd0, d); chk("post_rst_spcr", d, 8'h00);
    bus_rd(3'd3, d); chk("post_rst_bcnt", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
